// File: rtl/mcs6530_pkg.sv
// Shared types and constants for the mcs6530 bus initiator: FSM states, idle bus
// levels and the -002 part's region bases.
package mcs6530_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_WAIT,
    ST_SAMPLE,
    ST_RESP
  } state_t;

  localparam logic [9:0] IDLE_A   = 10'h000;
  localparam logic       IDLE_RS0 = 1'b1;
  localparam logic       IDLE_CS1 = 1'b0;

  localparam logic [9:0] RAM_BASE   = 10'h3C0;
  localparam logic [9:0] IO_BASE    = 10'h340;
  localparam logic [9:0] TIMER_BASE = 10'h344;

endpackage

// File: rtl/mcs6530_irq_latch.sv
// Falling-edge IRQ latch: a pending flag cleared by irq_clr and a wrapping event counter.
module mcs6530_irq_latch (
  input  logic       phi2,
  input  logic       rst,
  input  logic       irq,
  input  logic       irq_clr,
  output logic       irq_pending,
  output logic [7:0] irq_count
);

  logic irq_prev;

  // A fresh edge wins over a simultaneous clear so no interrupt is lost.
  always_ff @(posedge phi2) begin
    if (rst) begin
      irq_prev    <= 1'b1;
      irq_pending <= 1'b0;
      irq_count   <= 8'h00;
    end else begin
      irq_prev <= irq;
      if (irq_prev && !irq) begin
        irq_pending <= 1'b1;
        irq_count   <= irq_count + 8'd1;
      end else if (irq_clr) begin
        irq_pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mcs6530_bus_master.sv
// Valid/ready host requests to 6502-style read/write cycles on the mcs6530 bus.
// Optional IRQ latch is enabled by defining MCS6530_MASTER_IRQ_LATCH_EN.
module mcs6530_bus_master
  import mcs6530_pkg::*;
#(
  parameter int READ_LAT = 1
) (
  input  logic       phi2,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_we,
  input  logic [9:0] req_addr,
  input  logic       req_rs0,
  input  logic       req_cs1,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic [9:0] A,
  output logic [7:0] DI,
  output logic       we_n,
  output logic       RS0,
  output logic       CS1,
  input  logic [7:0] DO,
  input  logic       OE,
  input  logic       IRQ
`ifdef MCS6530_MASTER_IRQ_LATCH_EN
  ,
  input  logic       irq_clr,
  output logic       irq_pending,
  output logic [7:0] irq_count
`endif
);

  localparam logic [2:0] WAIT_INIT = 3'(READ_LAT - 1);

  state_t     state;
  logic       we_q;
  logic [2:0] wait_cnt;

  assign req_ready = (state == ST_IDLE) && !rst;

  always_ff @(posedge phi2) begin
    if (rst) begin
      state     <= ST_IDLE;
      we_q      <= 1'b0;
      wait_cnt  <= 3'd0;
      A         <= IDLE_A;
      DI        <= 8'h00;
      we_n      <= 1'b1;
      RS0       <= IDLE_RS0;
      CS1       <= IDLE_CS1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            state     <= ST_SETUP;
            we_q      <= req_we;
            A         <= req_addr;
            RS0       <= req_rs0;
            CS1       <= req_cs1;
            DI        <= req_we ? req_wdata : 8'h00;
            rsp_rdata <= 8'h00;
            rsp_err   <= 1'b0;
          end
        end
        ST_SETUP: begin
          if (we_q) begin
            state <= ST_STROBE;
            we_n  <= 1'b0;
          end else begin
            state    <= ST_WAIT;
            wait_cnt <= WAIT_INIT;
          end
        end
        ST_STROBE: begin
          state <= ST_HOLD;
          we_n  <= 1'b1;
        end
        ST_HOLD: begin
          state     <= ST_RESP;
          rsp_valid <= 1'b1;
          A         <= IDLE_A;
          DI        <= 8'h00;
          RS0       <= IDLE_RS0;
          CS1       <= IDLE_CS1;
        end
        ST_WAIT: begin
          if (wait_cnt == 3'd0) state <= ST_SAMPLE;
          else wait_cnt <= wait_cnt - 3'd1;
        end
        ST_SAMPLE: begin
          // Nobody driving the bus reads as zero with the error flag set.
          state     <= ST_RESP;
          rsp_valid <= 1'b1;
          rsp_rdata <= OE ? DO : 8'h00;
          rsp_err   <= !OE;
          A         <= IDLE_A;
          DI        <= 8'h00;
          RS0       <= IDLE_RS0;
          CS1       <= IDLE_CS1;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef MCS6530_MASTER_IRQ_LATCH_EN
  mcs6530_irq_latch u_irq_latch (
    .phi2        (phi2),
    .rst         (rst),
    .irq         (IRQ),
    .irq_clr     (irq_clr),
    .irq_pending (irq_pending),
    .irq_count   (irq_count)
  );
`else
  logic unused_irq;
  assign unused_irq = IRQ;
`endif

endmodule

// File: tb/tb_mcs6530_bus_master.sv
// Directed bench for mcs6530_bus_master with a small behavioural mcs6530 responder.
module tb_mcs6530_bus_master;
  import mcs6530_pkg::*;

  logic       phi2 = 1'b0;
  logic       rst, req_valid, req_we, req_rs0, req_cs1, rsp_ready, OE, IRQ;
  logic       req_ready, rsp_valid, rsp_err, we_n, RS0, CS1;
  logic [9:0] req_addr, A;
  logic [7:0] req_wdata, rsp_rdata, DI, DO;
`ifdef MCS6530_MASTER_IRQ_LATCH_EN
  logic       irq_clr, irq_pending;
  logic [7:0] irq_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  mcs6530_bus_master #(.READ_LAT(1)) dut (
    .phi2(phi2), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_rs0(req_rs0), .req_cs1(req_cs1),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .A(A), .DI(DI), .we_n(we_n),
    .RS0(RS0), .CS1(CS1), .DO(DO), .OE(OE), .IRQ(IRQ)
`ifdef MCS6530_MASTER_IRQ_LATCH_EN
    , .irq_clr(irq_clr), .irq_pending(irq_pending), .irq_count(irq_count)
`endif
  );

  always #5 phi2 = ~phi2;

  // Responder: 64-byte RAM at RAM_BASE, two fixed registers for the IO and timer
  // windows, nothing elsewhere. Selected when RS0=1 and CS1=0.
  logic [7:0] mem [0:63];
  logic       ram_sel, io_sel, tmr_sel;
  always_comb begin
    ram_sel = RS0 && !CS1 && (A[9:6] == RAM_BASE[9:6]);
    io_sel  = RS0 && !CS1 && (A[9:2] == IO_BASE[9:2]);
    tmr_sel = RS0 && !CS1 && (A[9:2] == TIMER_BASE[9:2]);
    OE = we_n && (ram_sel || io_sel || tmr_sel);
    DO = 8'h00;
    if (ram_sel) DO = mem[A[5:0]];
    else if (io_sel) DO = 8'h11;
    else if (tmr_sel) DO = 8'h22;
  end
  always @(posedge phi2) if (!we_n && ram_sel) mem[A[5:0]] <= DI;

  int         we_low = 0;
  logic [9:0] strobe_a;
  logic [7:0] strobe_di;
  always @(negedge phi2) if (we_n === 1'b0) begin
    we_low++;
    strobe_a  = A;
    strobe_di = DI;
  end

  int cyc = 0;
  int n_acc = 0;
  bit logging = 0;
  int acc_t [0:3];
  always @(posedge phi2) begin
    cyc++;
    if (logging && req_valid && req_ready && n_acc < 4) begin
      acc_t[n_acc] = cyc;
      n_acc++;
    end
  end

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic start_req(input logic we, input logic [9:0] addr, input logic [7:0] wd,
                           output bit ok);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_rs0 = 1'b1; req_cs1 = 1'b0;
    req_wdata = wd; ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (req_ready) ok = 1'b1;
      @(posedge phi2);
      @(negedge phi2);
    end
    req_valid = 1'b0; req_we = ~we; req_addr = ~addr; req_wdata = ~wd; req_rs0 = 1'b0;
  endtask

  // Latency in cycles with the accept edge as cycle 0; 99 when nothing arrives.
  task automatic wait_rsp(output int lat);
    lat = 99;
    for (int n = 0; n < 20; n++) begin
      if (rsp_valid) begin
        lat = n + 1;
        break;
      end
      @(negedge phi2);
    end
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(posedge phi2);
    @(negedge phi2);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge phi2);
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL reset_req_ready got=%b want=0", req_ready); end
    n_cmp++; if ({rsp_valid, rsp_err, rsp_rdata} !== 10'h000) begin n_bad++; $display("FAIL reset_rsp got=%b/%b/%h want=0/0/00", rsp_valid, rsp_err, rsp_rdata); end
    n_cmp++; if ({A, DI, we_n, RS0, CS1} !== {10'h000, 8'h00, 3'b110}) begin n_bad++; $display("FAIL reset_bus got A=%h DI=%h we_n=%b RS0=%b CS1=%b want 000/00/1/1/0", A, DI, we_n, RS0, CS1); end
`ifdef MCS6530_MASTER_IRQ_LATCH_EN
    n_cmp++; if ({irq_pending, irq_count} !== 9'h000) begin n_bad++; $display("FAIL reset_irq got=%b/%h want=0/00", irq_pending, irq_count); end
`endif
    rst = 1'b0;
    @(negedge phi2);
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL ready_after_reset got=%b want=1", req_ready); end
  endtask

  task automatic test_write_read();
    bit ok; int lat;
    we_low = 0;
    start_req(1'b1, 10'h3C5, 8'h5A, ok);
    wait_rsp(lat);
    n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL write_latency got=%0d want=4", lat); end
    n_cmp++; if (we_low !== 1) begin n_bad++; $display("FAIL we_n_low_cycles got=%0d want=1", we_low); end
    n_cmp++; if ({strobe_a, strobe_di} !== {10'h3C5, 8'h5A}) begin n_bad++; $display("FAIL strobe_bus got=%h/%h want=3c5/5a", strobe_a, strobe_di); end
    n_cmp++; if ({rsp_err, rsp_rdata} !== 9'h000) begin n_bad++; $display("FAIL write_rsp got=%b/%h want=0/00", rsp_err, rsp_rdata); end
    take_rsp();
    start_req(1'b0, 10'h3C5, 8'h00, ok);
    wait_rsp(lat);
    n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL read_latency got=%0d want=4", lat); end
    n_cmp++; if ({rsp_err, rsp_rdata} !== {1'b0, 8'h5A}) begin n_bad++; $display("FAIL read_back got=%b/%h want=0/5a", rsp_err, rsp_rdata); end
    n_cmp++; if ({A, we_n} !== {10'h000, 1'b1}) begin n_bad++; $display("FAIL bus_idle_in_resp got=%h/%b want=000/1", A, we_n); end
    take_rsp();
    n_cmp++; if ({rsp_valid, req_ready} !== 2'b01) begin n_bad++; $display("FAIL after_handshake got=%b%b want=01", rsp_valid, req_ready); end
  endtask

  task automatic test_unmapped();
    bit ok; int lat;
    start_req(1'b0, 10'h000, 8'h00, ok);
    wait_rsp(lat);
    n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL unmapped_latency got=%0d want=4", lat); end
    n_cmp++; if ({rsp_err, rsp_rdata} !== {1'b1, 8'h00}) begin n_bad++; $display("FAIL unmapped_rsp got=%b/%h want=1/00", rsp_err, rsp_rdata); end
    take_rsp();
  endtask

  task automatic test_regions();
    bit ok; int lat;
    start_req(1'b0, 10'h341, 8'h00, ok); wait_rsp(lat);
    n_cmp++; if ({rsp_err, rsp_rdata} !== {1'b0, 8'h11}) begin n_bad++; $display("FAIL io_read got=%b/%h want=0/11", rsp_err, rsp_rdata); end
    take_rsp();
    start_req(1'b0, 10'h345, 8'h00, ok); wait_rsp(lat);
    n_cmp++; if ({rsp_err, rsp_rdata} !== {1'b0, 8'h22}) begin n_bad++; $display("FAIL timer_read got=%b/%h want=0/22", rsp_err, rsp_rdata); end
    take_rsp();
    start_req(1'b1, 10'h3C0, 8'hA3, ok); wait_rsp(lat); take_rsp();
    start_req(1'b1, 10'h3FF, 8'h3C, ok); wait_rsp(lat); take_rsp();
    start_req(1'b0, 10'h3C0, 8'h00, ok); wait_rsp(lat);
    n_cmp++; if (rsp_rdata !== 8'hA3) begin n_bad++; $display("FAIL ram_low_edge got=%h want=a3", rsp_rdata); end
    take_rsp();
    start_req(1'b0, 10'h3FF, 8'h00, ok); wait_rsp(lat);
    n_cmp++; if (rsp_rdata !== 8'h3C) begin n_bad++; $display("FAIL ram_high_edge got=%h want=3c", rsp_rdata); end
    take_rsp();
  endtask

  task automatic test_rsp_stall();
    bit ok; int lat; int bad_cycles;
    start_req(1'b0, 10'h3C5, 8'h00, ok);
    wait_rsp(lat);
    bad_cycles = 0;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h5A || req_ready !== 1'b0 ||
          A !== 10'h000 || we_n !== 1'b1) bad_cycles++;
      @(negedge phi2);
    end
    n_cmp++; if (bad_cycles !== 0) begin n_bad++; $display("FAIL stall_hold bad_cycles=%0d want=0", bad_cycles); end
    n_cmp++; if ({rsp_valid, rsp_rdata} !== {1'b1, 8'h5A}) begin n_bad++; $display("FAIL stall_end got=%b/%h want=1/5a", rsp_valid, rsp_rdata); end
    take_rsp();
  endtask

  task automatic test_abort();
    bit ok; int seen;
    start_req(1'b1, 10'h3C6, 8'h77, ok);
    @(negedge phi2);
    n_cmp++; if (we_n !== 1'b0) begin n_bad++; $display("FAIL abort_in_strobe got we_n=%b want=0", we_n); end
    rst = 1'b1;
    @(negedge phi2);
    rst = 1'b0;
    n_cmp++; if ({we_n, A, DI, rsp_valid} !== {1'b1, 10'h000, 8'h00, 1'b0}) begin n_bad++; $display("FAIL abort_bus got we_n=%b A=%h DI=%h vld=%b want 1/000/00/0", we_n, A, DI, rsp_valid); end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge phi2);
      if (rsp_valid) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL abort_no_rsp got=%0d want=0", seen); end
  endtask

  task automatic test_back_to_back();
    int gap0, gap1;
    n_acc = 0; logging = 1'b1; rsp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 10'h3C5; req_rs0 = 1'b1; req_cs1 = 1'b0;
    req_wdata = 8'h00;
    for (int i = 0; i < 40 && n_acc < 3; i++) @(negedge phi2);
    req_valid = 1'b0; logging = 1'b0;
    n_cmp++; if (n_acc !== 3) begin n_bad++; $display("FAIL b2b_accepts got=%0d want=3", n_acc); end
    gap0 = acc_t[1] - acc_t[0];
    gap1 = acc_t[2] - acc_t[1];
    n_cmp++; if (gap0 !== 5 || gap1 !== 5) begin n_bad++; $display("FAIL b2b_period got=%0d,%0d want=5,5", gap0, gap1); end
    for (int i = 0; i < 10 && !(req_ready && !rsp_valid && i > 4); i++) @(negedge phi2);
    rsp_ready = 1'b0;
    n_cmp++; if ({req_ready, rsp_valid, rsp_rdata} !== {2'b10, 8'h5A}) begin n_bad++; $display("FAIL b2b_last got=%b%b/%h want=10/5a", req_ready, rsp_valid, rsp_rdata); end
  endtask

`ifdef MCS6530_MASTER_IRQ_LATCH_EN
  task automatic test_irq();
    for (int k = 0; k < 2; k++) begin
      IRQ = 1'b0; @(negedge phi2);
      IRQ = 1'b1; @(negedge phi2);
    end
    n_cmp++; if ({irq_pending, irq_count} !== {1'b1, 8'd2}) begin n_bad++; $display("FAIL irq_two_edges got=%b/%0d want=1/2", irq_pending, irq_count); end
    irq_clr = 1'b1; @(negedge phi2); irq_clr = 1'b0;
    n_cmp++; if ({irq_pending, irq_count} !== {1'b0, 8'd2}) begin n_bad++; $display("FAIL irq_clear got=%b/%0d want=0/2", irq_pending, irq_count); end
    IRQ = 1'b0; irq_clr = 1'b1; @(negedge phi2); irq_clr = 1'b0; IRQ = 1'b1;
    @(negedge phi2);
    n_cmp++; if ({irq_pending, irq_count} !== {1'b1, 8'd3}) begin n_bad++; $display("FAIL irq_edge_beats_clr got=%b/%0d want=1/3", irq_pending, irq_count); end
  endtask
`endif

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_rs0 = 1'b1;
    req_cs1 = 1'b0; req_wdata = '0; rsp_ready = 1'b0; IRQ = 1'b1;
`ifdef MCS6530_MASTER_IRQ_LATCH_EN
    irq_clr = 1'b0;
`endif
    @(negedge phi2);
    test_reset();
    test_write_read();
    test_unmapped();
    test_regions();
    test_rsp_stall();
    test_abort();
    test_back_to_back();
`ifdef MCS6530_MASTER_IRQ_LATCH_EN
    test_irq();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
